pcs_rx_framer: RTL and testbench
================================

# pcs_rx_framer

Receive-side PCS framer that consumes the 4-lane PAM5 decisions from the look-ahead DFE decoder (12-bit packed symbol word plus valid) and produces a byte stream with frame delineation. It classifies every 4D symbol as IDLE, SSD, ESD, DATA or INVALID. A frame state machine extracts one byte per valid DATA symbol and optionally descrambles it. Per-frame status goes to the MAC-facing receive logic.

## Interface
- MAX_LEN, 1518: maximum data bytes per frame; exceeding it is an error
- SCR_SEED, 15'h7FFF: descrambler LFSR load value at SSD (used only with the descrambler compiled in)
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_rxSymbols  input  12  packed decisions: [11:9]=sym0, [8:6]=sym1, [5:3]=sym2, [2:0]=sym3, each 3-bit two's complement
- io_rxValid  input  1  io_rxSymbols valid this cycle
- io_rxData  output  8  received byte
- io_rxDv  output  1  io_rxData valid (data byte inside a frame)
- io_rxEr  output  1  one-cycle frame error pulse
- io_frameDone  output  1  one-cycle pulse on good frame end (ESD)
- io_frameLen  output  11  byte count of last good frame, held until the next ESD
- io_inFrame  output  1  state machine is in DATA

## Operation
- Lane decode: -2 (110) → 00, -1 (111) → 01, +1 (001) → 10, +2 (010) → 11. 0 (000) marks a control lane. 011, 100 and 101 are illegal.
- Classification (sym0..sym3):
  - IDLE = (0,0,0,0)
  - SSD = (+2,0,0,+2)
  - ESD = (-2,0,0,-2)
  - DATA = no zero and no illegal lane
  - INVALID = anything else
- Raw data byte = {lane0, lane1, lane2, lane3} codes; lane0 occupies bits [7:6].
- States: IDLE, DATA, ERR. Only cycles with io_rxValid=1 are evaluated. When io_rxValid=0, state, counter and LFSR are held and io_rxDv=0.
- IDLE:
  - SSD → DATA, byte counter cleared, LFSR loaded with SCR_SEED.
  - Every other class stays in IDLE, with no outputs asserted.
- DATA:
  - DATA symbol → emit byte, counter+1.
  - ESD → IDLE, io_frameDone=1, io_frameLen=counter.
  - IDLE, SSD or INVALID → ERR.
  - A DATA symbol when counter==MAX_LEN → ERR; that byte is not emitted.
- ERR:
  - io_rxEr=1 for exactly one cycle.
  - The next valid cycle returns to IDLE unconditionally; an SSD in that cycle is ignored.
  - io_frameLen is not updated.
- ESD with counter==0 is a good zero-length frame: io_frameDone=1, io_frameLen=0.
- Counter saturates at MAX_LEN and is 11 bits wide. MAX_LEN must be ≤ 2047.

## Timing
- All outputs are registered. Latency is 1 cycle from the io_rxValid cycle to the output cycle.
- io_rxDv, io_rxEr and io_frameDone are mutually exclusive single-cycle pulses per input symbol.
- Reset values:
  - state IDLE
  - io_rxData=0, io_rxDv=0, io_rxEr=0, io_frameDone=0, io_inFrame=0
  - io_frameLen=0
  - LFSR=SCR_SEED
- Asserting reset mid-frame aborts the frame immediately: no io_rxEr and no io_frameDone.
- io_inFrame rises the cycle after the SSD is accepted. It falls the cycle after the ESD, or when ERR is entered.

## Configuration
- PCS_RX_DESCRAMBLE_EN defined: 15-bit LFSR descrambler is enabled.
  - For each data byte, 8 steps are taken, bit 0 first.
  - Each step: fb = s[14]^s[13], then s = {s[13:0], fb}.
  - Keystream bit i = fb of step i.
  - io_rxData = raw ^ keystream.
  - The LFSR advances only on emitted DATA bytes.
- Macro undefined: io_rxData = raw byte. No LFSR flops are instantiated, and SCR_SEED is ignored.

## Structure
- Shared package pcs_rx_pkg contains:
  - symbol class enum (SYM_IDLE, SYM_SSD, SYM_ESD, SYM_DATA, SYM_INVALID)
  - state enum
  - PAM5 lane code constants
  - SSD and ESD pattern constants
  - LFSR polynomial taps
- One sub-module, pcs_rx_symclass: combinational classifier that takes the 12-bit word and returns the class and the raw byte.
- The top level holds the FSM, counter, LFSR and output registers.

## Test plan
- Descrambler compiled out; IDLE ×3, SSD, (+1,-1,+2,-2), (-2,-2,-2,-2), ESD → bytes 0x9C then 0x00 with io_rxDv; io_frameDone=1, io_frameLen=2; io_inFrame high for exactly 3 cycles.
- SSD, DATA (+1,+1,+1,+1), (0,+1,+1,+1) → one byte 0xAA, then io_rxEr=1 for one cycle, then IDLE; the following SSD starts a new frame normally.
- MAX_LEN=4: SSD then 5 DATA symbols → 4 bytes emitted, io_rxEr on the 5th; io_frameLen unchanged from the previous value.
- io_rxValid toggling 1/0 every cycle through a 3-byte frame → identical bytes and io_frameLen=3 as with continuous valid; io_rxDv=0 in gap cycles.
- Reset asserted mid-frame after 2 bytes → outputs go to reset values at once; no io_rxEr and no io_frameDone; next SSD and ESD give io_frameLen=0.
- PCS_RX_DESCRAMBLE_EN, SCR_SEED=15'h0001, 40 random DATA symbols → io_rxData ^ raw equals the bench LFSR model byte-for-byte; the LFSR is reloaded on the second SSD.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared types and constants for the PCS receive framer.
// Symbol classes, framer states, PAM5 lane codes, control patterns,
// and the descrambler LFSR taps with a byte-step helper.
package pcs_rx_pkg;

    typedef enum logic [2:0] {
        SYM_IDLE,
        SYM_SSD,
        SYM_ESD,
        SYM_DATA,
        SYM_INVALID
    } sym_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR
    } state_e;

    // PAM5 lane decisions, 3-bit two's complement
    localparam logic [2:0] PAM_M2 = 3'b110;
    localparam logic [2:0] PAM_M1 = 3'b111;
    localparam logic [2:0] PAM_Z  = 3'b000;
    localparam logic [2:0] PAM_P1 = 3'b001;
    localparam logic [2:0] PAM_P2 = 3'b010;

    // Frame delimiters, lane0 in the MSBs
    localparam logic [11:0] SSD_PAT = {PAM_P2, PAM_Z, PAM_Z, PAM_P2};
    localparam logic [11:0] ESD_PAT = {PAM_M2, PAM_Z, PAM_Z, PAM_M2};

    // Descrambler feedback taps
    localparam int LFSR_TAP_HI = 14;
    localparam int LFSR_TAP_LO = 13;

    typedef struct packed {
        logic [14:0] s;
        logic [7:0]  ks;
    } lfsr_out_t;

    // Eight LFSR steps; keystream bit i is the feedback of step i
    function automatic lfsr_out_t lfsr_byte(input logic [14:0] s_in);
        lfsr_out_t r;
        logic [14:0] s;
        logic fb;
        s    = s_in;
        r.ks = '0;
        for (int i = 0; i < 8; i++) begin
            fb      = s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO];
            r.ks[i] = fb;
            s       = {s[13:0], fb};
        end
        r.s = s;
        return r;
    endfunction

endpackage

// File: rtl/pcs_rx_symclass.sv
// Combinational 4D symbol classifier: decodes each PAM5 lane to a 2-bit
// code and labels the symbol IDLE / SSD / ESD / DATA / INVALID.
module pcs_rx_symclass
    import pcs_rx_pkg::*;
(
    input  logic [11:0] sym,
    output sym_class_e  cls,
    output logic [7:0]  raw
);

    logic       any_zero;
    logic       any_ill;
    logic [2:0] lane;
    logic [1:0] code;

    // Per-lane decode; lane0 (sym[11:9]) lands in raw[7:6]
    always_comb begin
        any_zero = 1'b0;
        any_ill  = 1'b0;
        raw      = '0;
        lane     = '0;
        code     = '0;
        for (int i = 0; i < 4; i++) begin
            lane = sym[11-3*i -: 3];
            code = 2'b00;
            case (lane)
                PAM_M2:  code = 2'b00;
                PAM_M1:  code = 2'b01;
                PAM_P1:  code = 2'b10;
                PAM_P2:  code = 2'b11;
                PAM_Z:   any_zero = 1'b1;
                default: any_ill  = 1'b1;
            endcase
            raw[7-2*i -: 2] = code;
        end
    end

    // Control patterns take priority over the generic data check
    always_comb begin
        if (sym == 12'h000)              cls = SYM_IDLE;
        else if (sym == SSD_PAT)         cls = SYM_SSD;
        else if (sym == ESD_PAT)         cls = SYM_ESD;
        else if (!any_zero && !any_ill)  cls = SYM_DATA;
        else                             cls = SYM_INVALID;
    end

endmodule

// File: rtl/pcs_rx_framer.sv
// PCS receive framer: symbol classification, frame FSM, byte counter,
// optional descrambler and registered MAC-facing outputs.
// Define PCS_RX_DESCRAMBLE_EN to compile in the 15-bit LFSR descrambler.
module pcs_rx_framer
    import pcs_rx_pkg::*;
#(
    parameter int          MAX_LEN  = 1518,
    parameter logic [14:0] SCR_SEED = 15'h7FFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] io_rxSymbols,
    input  logic        io_rxValid,
    output logic [7:0]  io_rxData,
    output logic        io_rxDv,
    output logic        io_rxEr,
    output logic        io_frameDone,
    output logic [10:0] io_frameLen,
    output logic        io_inFrame
);

    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    sym_class_e  cls;
    logic [7:0]  raw;
    logic [7:0]  ks;
    state_e      state, state_nxt;
    logic [10:0] cnt;
    logic        emit, err_nxt, done_nxt, sof;

    pcs_rx_symclass u_symclass (
        .sym (io_rxSymbols),
        .cls (cls),
        .raw (raw)
    );

    assign sof = io_rxValid && (state == ST_IDLE) && (cls == SYM_SSD);

    // Next state and one-cycle event decode for the current valid symbol
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        if (io_rxValid) begin
            case (state)
                ST_IDLE: if (cls == SYM_SSD) state_nxt = ST_DATA;
                ST_DATA: begin
                    if (cls == SYM_DATA && cnt != MAX_L) begin
                        emit = 1'b1;
                    end else if (cls == SYM_ESD) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        // overlong frame, stray control or bad symbol
                        state_nxt = ST_ERR;
                        err_nxt   = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef PCS_RX_DESCRAMBLE_EN
    logic [14:0] lfsr;
    lfsr_out_t   step;

    assign step = lfsr_byte(lfsr);
    assign ks   = step.ks;

    // Reload at every frame start, advance only on bytes actually emitted
    always_ff @(posedge clock or posedge reset) begin
        if (reset)      lfsr <= SCR_SEED;
        else if (sof)   lfsr <= SCR_SEED;
        else if (emit)  lfsr <= step.s;
    end
`else
    logic unused_seed;
    assign unused_seed = ^SCR_SEED;
    assign ks          = '0;
`endif

    // FSM, byte counter and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            io_rxData    <= '0;
            io_rxDv      <= 1'b0;
            io_rxEr      <= 1'b0;
            io_frameDone <= 1'b0;
            io_frameLen  <= '0;
            io_inFrame   <= 1'b0;
        end else begin
            state        <= state_nxt;
            io_inFrame   <= (state_nxt == ST_DATA);
            io_rxDv      <= emit;
            io_rxEr      <= err_nxt;
            io_frameDone <= done_nxt;
            if (sof) cnt <= '0;
            if (emit) begin
                io_rxData <= raw ^ ks;
                cnt       <= cnt + 11'd1;
            end
            if (done_nxt) io_frameLen <= cnt;
        end
    end

endmodule

// File: tb/tb_pcs_rx_framer.sv
// Scoreboard bench for pcs_rx_framer: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT emits.
module tb_pcs_rx_framer;

    localparam logic [11:0] S_IDLE = 12'h000;
    localparam logic [11:0] S_SSD  = 12'b010_000_000_010;
    localparam logic [11:0] S_ESD  = 12'b110_000_000_110;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // main DUT (default MAX_LEN, seed 1)
    logic [11:0] sym;
    logic        vld;
    logic [7:0]  data;
    logic        dv, er, done, infr;
    logic [10:0] flen;

    // short-frame DUT (MAX_LEN=4)
    logic [11:0] sym4;
    logic        vld4;
    logic [7:0]  data4;
    logic        dv4, er4, done4, infr4;
    logic [10:0] flen4;

    pcs_rx_framer #(.MAX_LEN(1518), .SCR_SEED(15'h0001)) dut (
        .clock(clock), .reset(reset), .io_rxSymbols(sym), .io_rxValid(vld),
        .io_rxData(data), .io_rxDv(dv), .io_rxEr(er), .io_frameDone(done),
        .io_frameLen(flen), .io_inFrame(infr)
    );

    pcs_rx_framer #(.MAX_LEN(4), .SCR_SEED(15'h0001)) dut4 (
        .clock(clock), .reset(reset), .io_rxSymbols(sym4), .io_rxValid(vld4),
        .io_rxData(data4), .io_rxDv(dv4), .io_rxEr(er4), .io_frameDone(done4),
        .io_frameLen(flen4), .io_inFrame(infr4)
    );

    typedef struct {
        int          kind;   // 0 = byte, 1 = error, 2 = frame done
        logic [7:0]  data;
        logic [10:0] len;
    } ev_t;

    ev_t q[$];
    ev_t q4[$];
    int  checks     = 0;
    int  failures   = 0;
    int  infr_cycles = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit which, input int kind, input logic [7:0] d, input logic [10:0] l);
        ev_t e;
        e.kind = kind; e.data = d; e.len = l;
        if (which) q4.push_back(e);
        else       q.push_back(e);
    endtask

    task automatic mon_one(input bit which, input logic v, input logic e_, input logic dn,
                           input logic [7:0] d, input logic [10:0] l);
        ev_t e;
        int  k;
        if (v || e_ || dn) begin
            k = v ? 0 : (e_ ? 1 : 2);
            chk(which ? "excl4" : "excl", 32'(v) + 32'(e_) + 32'(dn), 1);
            if ((which ? q4.size() : q.size()) == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event dut%0d: kind %0d data %0h len %0d, none expected",
                         which ? 4 : 0, k, d, l);
            end else begin
                e = which ? q4.pop_front() : q.pop_front();
                chk(which ? "kind4" : "kind", k, e.kind);
                if (e.kind == 0) chk(which ? "rxData4" : "rxData", d, e.data);
                else             chk(which ? "frameLen4" : "frameLen", l, e.len);
            end
        end
    endtask

    // Monitor: outputs settle after posedge, sampled on the falling edge
    always @(negedge clock) begin
        if (!reset) begin
            if (infr) infr_cycles++;
            mon_one(1'b0, dv, er, done, data, flen);
            mon_one(1'b1, dv4, er4, done4, data4, flen4);
        end
    end

    task automatic send(input logic [11:0] s, input logic v);
        sym = s; vld = v;
        @(negedge clock);
    endtask

    task automatic send4(input logic [11:0] s);
        sym4 = s; vld4 = 1'b1;
        @(negedge clock);
        vld4 = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    int          c0;
    logic [11:0] s;
    logic [7:0]  rawb, ks;
    logic [14:0] m;
    logic [1:0]  ln;
    logic        fb;

    initial begin
        reset = 1'b1; sym = '0; vld = 1'b0; sym4 = '0; vld4 = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_rxDv", dv, 0);
        chk("rst_rxEr", er, 0);
        chk("rst_done", done, 0);
        chk("rst_inFrame", infr, 0);
        chk("rst_frameLen", flen, 0);
        chk("rst_rxData", data, 0);
        reset = 1'b0;
        @(negedge clock);

        // basic frame: 0x9C, 0x00, len 2, inFrame for 3 cycles
        c0 = infr_cycles;
        send(S_IDLE, 1); send(S_IDLE, 1); send(S_IDLE, 1);
        send(S_SSD, 1);
        push(0, 0, 8'h9C, 0); send(12'b001_111_010_110, 1);
        push(0, 0, 8'h00, 0); send(12'b110_110_110_110, 1);
        push(0, 2, 0, 11'd2); send(S_ESD, 1);
        idle(2);
        chk("inFrame_cycles", infr_cycles - c0, 3);

        // bad symbol mid-frame, SSD in ERR cycle ignored, then clean frame
        send(S_SSD, 1);
        push(0, 0, 8'hAA, 0); send(12'b001_001_001_001, 1);
        push(0, 1, 0, 11'd2); send(12'b000_001_001_001, 1);
        send(S_SSD, 1);              // consumed by ERR -> IDLE
        send(S_ESD, 1);              // IDLE: no output
        chk("inFrame_after_err", infr, 0);
        send(S_SSD, 1);
        push(0, 0, 8'hFF, 0); send(12'b010_010_010_010, 1);
        push(0, 2, 0, 11'd1); send(S_ESD, 1);
        idle(2);

        // valid toggling; gaps carry an SSD that must be ignored
        send(S_SSD, 1); send(S_SSD, 0);
        push(0, 0, 8'h1B, 0); send(12'b110_111_001_010, 1); send(S_SSD, 0);
        push(0, 0, 8'hFF, 0); send(12'b010_010_010_010, 1); send(S_SSD, 0);
        push(0, 0, 8'h66, 0); send(12'b111_001_111_001, 1); send(S_SSD, 0);
        push(0, 2, 0, 11'd3); send(S_ESD, 1);
        idle(2);
        chk("frameLen_hold", flen, 3);

        // reset mid-frame after 2 bytes
        send(S_SSD, 1);
        push(0, 0, 8'hAA, 0); send(12'b001_001_001_001, 1);
        push(0, 0, 8'hFF, 0); send(12'b010_010_010_010, 1);
        vld = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midrst_rxDv", dv, 0);
        chk("midrst_inFrame", infr, 0);
        chk("midrst_frameLen", flen, 0);
        chk("midrst_rxData", data, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send(S_SSD, 1);
        push(0, 2, 0, 11'd0); send(S_ESD, 1);
        idle(2);

        // MAX_LEN=4 instance: good frame len 2, then overlong frame
        send4(S_SSD);
        push(1, 0, 8'h9C, 0); send4(12'b001_111_010_110);
        push(1, 0, 8'hAA, 0); send4(12'b001_001_001_001);
        push(1, 2, 0, 11'd2); send4(S_ESD);
        send4(S_SSD);
        push(1, 0, 8'h00, 0); send4(12'b110_110_110_110);
        push(1, 0, 8'hFF, 0); send4(12'b010_010_010_010);
        push(1, 0, 8'h1B, 0); send4(12'b110_111_001_010);
        push(1, 0, 8'h66, 0); send4(12'b111_001_111_001);
        push(1, 1, 0, 11'd2); send4(12'b001_001_001_001);
        repeat (3) @(negedge clock);
        chk("max_frameLen_hold", flen4, 2);

        // two frames of 20 random data symbols; keystream reloads at each SSD
        for (int f = 0; f < 2; f++) begin
            send(S_SSD, 1);
            m = 15'h0001;
            for (int n = 0; n < 20; n++) begin
                rawb = '0;
                for (int l = 0; l < 4; l++) begin
                    ln = 2'($urandom_range(0, 3));
                    rawb[7-2*l -: 2] = ln;
                    case (ln)
                        2'd0: s[11-3*l -: 3] = 3'b110;
                        2'd1: s[11-3*l -: 3] = 3'b111;
                        2'd2: s[11-3*l -: 3] = 3'b001;
                        default: s[11-3*l -: 3] = 3'b010;
                    endcase
                end
                ks = '0;
                for (int b = 0; b < 8; b++) begin
                    fb = m[14] ^ m[13];
                    ks[b] = fb;
                    m = {m[13:0], fb};
                end
`ifndef PCS_RX_DESCRAMBLE_EN
                ks = '0;
`endif
                push(0, 0, rawb ^ ks, 0);
                send(s, 1);
            end
            push(0, 2, 0, 11'd20); send(S_ESD, 1);
            idle(2);
        end

        idle(3);
        chk("queue_drained", q.size(), 0);
        chk("queue4_drained", q4.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
